// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 stride-2 streaming pooling block.
package pool_pkg;

    typedef enum logic {
        FILL_ROW = 1'b0,
        POOL_ROW = 1'b1
    } pool_state_e;

    localparam logic MODE_MAX       = 1'b0;
    localparam logic MODE_AVG       = 1'b1;
    localparam int   DEFAULT_DATA_W = 18;

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer: single write port, two combinational read ports.
// Contents are not reset; every entry is rewritten on an even row before it is read.
module pool_line_buf #(
    parameter int DATA_W  = 18,
    parameter int IN_SIZE = 8,
    localparam int ADDR_W = $clog2(IN_SIZE)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem_q [IN_SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/pool2d_stream.sv
// Streaming 2x2 / stride-2 max pooling over a raster-ordered square feature map.
// Define POOL_AVG_EN to add the mode port and the floor-average datapath.
//
// state    | meaning
// FILL_ROW | even row: samples are written into the line buffer
// POOL_ROW | odd row: even col held in prev, odd col completes a window
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int IN_SIZE      = 8,
    parameter int FRAMES_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] datain,
    input  logic                     enable,
`ifdef POOL_AVG_EN
    input  logic                     mode,
`endif
    output logic signed [DATA_W-1:0] dataout,
    output logic                     pool_out,
    output logic                     pool_finish,
    output logic [FRAMES_CNT_W-1:0]  frame_cnt
);

    localparam int ADDR_W = $clog2(IN_SIZE);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IN_SIZE - 1);

    pool_state_e              state_q, state_d;
    logic [ADDR_W-1:0]        col_q, col_d, row_q, row_d;
    logic signed [DATA_W-1:0] prev_q, prev_d, dataout_q, dataout_d;
    logic                     pool_out_q, pool_out_d, finish_q, finish_d;
    logic [FRAMES_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    logic [DATA_W-1:0]        lb_rdata_a, lb_rdata_b;
    logic signed [DATA_W-1:0] win_a, win_b, max_ab, max_cd, win_max, win_res;
    logic                     last_col, last_row;

    pool_line_buf #(
        .DATA_W  (DATA_W),
        .IN_SIZE (IN_SIZE)
    ) u_line_buf (
        .clk     (clk),
        .we      (enable && (state_q == FILL_ROW)),
        .waddr   (col_q),
        .wdata   (datain),
        .raddr_a ({col_q[ADDR_W-1:1], 1'b0}),
        .raddr_b (col_q),
        .rdata_a (lb_rdata_a),
        .rdata_b (lb_rdata_b)
    );

    assign win_a   = $signed(lb_rdata_a);
    assign win_b   = $signed(lb_rdata_b);
    assign max_ab  = (win_a > win_b) ? win_a : win_b;
    assign max_cd  = (prev_q > datain) ? prev_q : datain;
    assign win_max = (max_ab > max_cd) ? max_ab : max_cd;

`ifdef POOL_AVG_EN
    logic signed [DATA_W+1:0] win_sum;
    logic signed [DATA_W-1:0] win_avg;
    logic [1:0]               win_sum_frac_unused;

    // Dropping the two low bits of a two's-complement sum floors toward -inf.
    assign win_sum = (DATA_W+2)'(win_a) + (DATA_W+2)'(win_b)
                   + (DATA_W+2)'(prev_q) + (DATA_W+2)'(datain);
    assign {win_avg, win_sum_frac_unused} = win_sum;
    assign win_res = (mode == MODE_AVG) ? win_avg : win_max;
`else
    assign win_res = win_max;
`endif

    assign last_col = (col_q == LAST_IDX);
    assign last_row = (row_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        prev_d      = prev_q;
        dataout_d   = dataout_q;
        pool_out_d  = 1'b0;
        finish_d    = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (enable) begin
            col_d = last_col ? '0 : col_q + 1'b1;
            if (last_col) begin
                row_d   = last_row ? '0 : row_q + 1'b1;
                state_d = (state_q == FILL_ROW) ? POOL_ROW : FILL_ROW;
            end
            if (state_q == POOL_ROW) begin
                if (!col_q[0]) begin
                    prev_d = datain;
                end else begin
                    dataout_d  = win_res;
                    pool_out_d = 1'b1;
                    if (last_col && last_row) begin
                        finish_d    = 1'b1;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL_ROW;
            col_q       <= '0;
            row_q       <= '0;
            prev_q      <= '0;
            dataout_q   <= '0;
            pool_out_q  <= 1'b0;
            finish_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            prev_q      <= prev_d;
            dataout_q   <= dataout_d;
            pool_out_q  <= pool_out_d;
            finish_q    <= finish_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign dataout     = dataout_q;
    assign pool_out    = pool_out_q;
    assign pool_finish = finish_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream with a 4x4 map; average-mode scenario runs when POOL_AVG_EN is defined.
module tb_pool2d_stream;

    logic               clk;
    logic               reset;
    logic signed [17:0] datain;
    logic               enable;
`ifdef POOL_AVG_EN
    logic               mode;
`endif
    logic signed [17:0] dataout;
    logic               pool_out;
    logic               pool_finish;
    logic [15:0]        frame_cnt;

    int tests;
    int fails;

    pool2d_stream #(
        .DATA_W       (18),
        .IN_SIZE      (4),
        .FRAMES_CNT_W (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .datain      (datain),
        .enable      (enable),
`ifdef POOL_AVG_EN
        .mode        (mode),
`endif
        .dataout     (dataout),
        .pool_out    (pool_out),
        .pool_finish (pool_finish),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of input, then look at outputs 1 time unit after the edge.
    task automatic step(input logic en, input int d);
        enable = en;
        datain = 18'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b1;
        datain = 18'sd500;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        datain = 18'sd77;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (dataout !== 18'sd0) begin fails++; $display("FAIL reset_dataout got %0d want 0", dataout); end
        tests++; if (pool_out !== 1'b0) begin fails++; $display("FAIL reset_pool_out got %b want 0", pool_out); end
        tests++; if (pool_finish !== 1'b0) begin fails++; $display("FAIL reset_finish got %b want 0", pool_finish); end
        tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        reset  = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_max();
        int exp_val [4] = '{5, 7, 13, 15};
        int n = 0;
        logic exp_po;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i);
            exp_po = (i % 2 == 1) && ((i / 4) % 2 == 1);
            tests++;
            if (pool_out !== exp_po) begin fails++; $display("FAIL max_pool_out[%0d] got %b want %b", i, pool_out, exp_po); end
            if (exp_po) begin
                tests++;
                if (dataout !== 18'(exp_val[n])) begin fails++; $display("FAIL max_value[%0d] got %0d want %0d", n, dataout, exp_val[n]); end
                tests++;
                if (pool_finish !== (i == 15)) begin fails++; $display("FAIL max_finish[%0d] got %b want %b", n, pool_finish, (i == 15)); end
                n++;
            end
        end
        tests++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL max_frame_cnt got %0d want 1", frame_cnt); end
    endtask

    task automatic test_enable_toggle();
        int exp_val [4] = '{5, 7, 13, 15};
        int n = 0;
        logic exp_po;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i);
            exp_po = (i % 2 == 1) && ((i / 4) % 2 == 1);
            tests++;
            if (pool_out !== exp_po) begin fails++; $display("FAIL tog_pool_out[%0d] got %b want %b", i, pool_out, exp_po); end
            if (exp_po) begin
                tests++;
                if (dataout !== 18'(exp_val[n])) begin fails++; $display("FAIL tog_value[%0d] got %0d want %0d", n, dataout, exp_val[n]); end
                n++;
            end
            step(1'b0, 1000);
            tests++;
            if (pool_out !== 1'b0 || pool_finish !== 1'b0) begin
                fails++; $display("FAIL tog_idle_strobe[%0d] got po=%b fin=%b want 0", i, pool_out, pool_finish);
            end
        end
        tests++; if (dataout !== 18'sd15) begin fails++; $display("FAIL tog_hold got %0d want 15", dataout); end
        tests++; if (frame_cnt !== 16'd2) begin fails++; $display("FAIL tog_frame_cnt got %0d want 2", frame_cnt); end
    endtask

`ifdef POOL_AVG_EN
    task automatic test_avg();
        int vals [16] = '{-1, -2, 1, 2, -3, -4, 3, 5, -5, -6, -7, -8, -9, -10, -11, -12};
        int exp_val [4] = '{-3, 2, -5, -7};
        int n = 0;
        for (int i = 0; i < 16; i++) begin
            mode = (i < 8) ? 1'b1 : 1'b0;
            step(1'b1, vals[i]);
            if ((i % 2 == 1) && ((i / 4) % 2 == 1)) begin
                tests++;
                if (pool_out !== 1'b1 || dataout !== 18'(exp_val[n])) begin
                    fails++; $display("FAIL avg_value[%0d] got %0d po=%b want %0d", n, dataout, pool_out, exp_val[n]);
                end
                n++;
            end
        end
        mode = 1'b0;
        tests++; if (frame_cnt !== 16'd3) begin fails++; $display("FAIL avg_frame_cnt got %0d want 3", frame_cnt); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int exp_val [4] = '{5, 7, 13, 15};
        int n = 0;
        int fin = 0;
        for (int i = 0; i < 10; i++) step(1'b1, i);
        do_reset();
        tests++;
        if (pool_out !== 1'b0 || frame_cnt !== 16'd0) begin
            fails++; $display("FAIL rst_mid_clear got po=%b cnt=%0d want 0 0", pool_out, frame_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i);
            if (pool_out) begin
                if (n < 4) begin
                    tests++;
                    if (dataout !== 18'(exp_val[n])) begin fails++; $display("FAIL rst_mid_value[%0d] got %0d want %0d", n, dataout, exp_val[n]); end
                end
                n++;
            end
            if (pool_finish) fin++;
        end
        step(1'b0, 0);
        tests++; if (n != 4) begin fails++; $display("FAIL rst_mid_count got %0d want 4", n); end
        tests++; if (fin != 1) begin fails++; $display("FAIL rst_mid_finish got %0d want 1", fin); end
        tests++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL rst_mid_frame_cnt got %0d want 1", frame_cnt); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int fin = 0;
        do_reset();
        for (int i = 0; i < 48; i++) begin
            step(1'b1, -131072);
            if (pool_out) begin
                n++;
                tests++;
                if (dataout !== -18'sd131072) begin fails++; $display("FAIL b2b_value[%0d] got %0d want -131072", n, dataout); end
            end
            if (pool_finish) fin++;
        end
        step(1'b0, 0);
        tests++; if (n != 12) begin fails++; $display("FAIL b2b_count got %0d want 12", n); end
        tests++; if (fin != 3) begin fails++; $display("FAIL b2b_finish got %0d want 3", fin); end
        tests++; if (frame_cnt !== 16'd3) begin fails++; $display("FAIL b2b_frame_cnt got %0d want 3", frame_cnt); end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        reset  = 1'b1;
        enable = 1'b0;
        datain = '0;
`ifdef POOL_AVG_EN
        mode   = 1'b0;
`endif
        test_reset();
        test_max();
        test_enable_toggle();
`ifdef POOL_AVG_EN
        test_avg();
`endif
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pool2d_stream.md
POOL2D_STREAM -- requirements
Module: pool2d_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 18: signed sample width.
REQ-002 SHALL have parameter IN_SIZE, default 8: square feature-map side, even, 4..256.
REQ-003 SHALL have parameter FRAMES_CNT_W, default 16: width of the frame counter.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port datain, input, DATA_W: signed sample, raster order, row-major.
REQ-007 SHALL have port enable, input, 1: datain valid this cycle; enable low stalls all state.
REQ-008 SHALL have port mode, input, 1: 0 = max, 1 = average; present only with POOL_AVG_EN.
REQ-009 SHALL have port dataout, output, DATA_W: pooled result, registered.
REQ-010 SHALL have port pool_out, output, 1: one-cycle strobe qualifying dataout.
REQ-011 SHALL have port pool_finish, output, 1: one-cycle strobe with the last output of a frame.
REQ-012 SHALL have port frame_cnt, output, FRAMES_CNT_W: completed frames, wraps at 2^FRAMES_CNT_W.

Function
REQ-013 SHALL implement a 2x2 window, stride 2, non-overlapping, producing (IN_SIZE/2)^2 outputs per frame.
REQ-014 SHALL track col and row counters (0..IN_SIZE-1), both advancing only on enable=1.
REQ-015 SHALL use FSM states FILL_ROW (even row) and POOL_ROW (odd row); reset state FILL_ROW.
REQ-016 SHALL move FILL_ROW->POOL_ROW and POOL_ROW->FILL_ROW on an accepted sample with col=IN_SIZE-1.
REQ-017 SHALL, in FILL_ROW, write each accepted sample into line buffer entry col.
REQ-018 SHALL, in POOL_ROW, hold the accepted even-col sample in a register prev.
REQ-019 SHALL, in POOL_ROW on an accepted odd-col sample, form a window from linebuf[col-1], linebuf[col], prev and datain.
REQ-020 SHALL, in max mode, output the signed maximum of the four window values.
REQ-021 SHALL, in average mode, sum the four values at DATA_W+2 bits and arithmetic-shift right 2 (floor toward -inf).
REQ-022 SHALL give a latency of exactly 1 cycle: dataout and pool_out are valid the cycle after the accepting edge.
REQ-023 SHALL drive pool_out=1 for exactly one cycle per result, regardless of enable in the following cycle.
REQ-024 SHALL hold dataout at its last result while pool_out=0.
REQ-025 SHALL assert pool_finish together with pool_out at row=col=IN_SIZE-1, wrap both counters to 0 and increment frame_cnt.
REQ-026 SHALL start the next frame on the cycle after the last sample; back-to-back frames need no idle cycle.
REQ-027 SHALL sample mode only at the accepting edge of each window's last sample; mode changes mid-frame affect only later windows.

Reset
REQ-028 SHALL, on reset=1, set dataout=0, pool_out=0, pool_finish=0, frame_cnt=0, col=row=0, state=FILL_ROW, prev=0.
REQ-029 SHALL give reset priority over enable; a reset mid-frame discards the partial frame without emitting output.
REQ-030 SHALL not clear the line buffer on reset; it is always rewritten before it is read.

Configuration
REQ-031 SHALL, with POOL_AVG_EN defined, provide the mode port and the average datapath.
REQ-032 SHALL, without POOL_AVG_EN, omit the mode port and the adder, and behave as max mode only.

Structure
REQ-033 SHALL place the state encoding, MODE_MAX=0/MODE_AVG=1 constants and the default DATA_W in the shared package pool_pkg.
REQ-034 SHALL implement the line buffer as sub-module pool_line_buf: IN_SIZE x DATA_W, one write port and two read ports (col-1, col).

Verification
REQ-035 SHALL verify max mode with IN_SIZE=4 and input 0..15 -> outputs 5, 7, 13, 15, with pool_finish on the 4th output.
REQ-036 SHALL verify average mode (POOL_AVG_EN) with window {-1, -2, -3, -4} -> -3; window {1, 2, 3, 5} -> 2.
REQ-037 SHALL verify that enable toggled 1/0 on every sample gives the same outputs as REQ-035, each 1 cycle after its accepting edge.
REQ-038 SHALL verify that reset after 10 samples of a frame, then a full frame 0..15, gives exactly 4 outputs, frame_cnt=1 and no spurious pool_out.
REQ-039 SHALL verify that 3 back-to-back frames of all -131072 (DATA_W=18) give dataout=-131072, frame_cnt=3 and three pool_finish pulses.
